// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//
// Purpose:
//   Computes a WIDTH-bit 74181-style operation by reusing one external 4-bit
//   74181-compatible ALU over NIB = WIDTH/4 clock cycles, one nibble per
//   cycle, least-significant nibble first. The ripple carry produced by the
//   ALU for one nibble is registered and fed back as the carry-in of the next
//   nibble. Requests and results use valid/ready handshakes.
//
// Parameters:
//   WIDTH      operand/result width, a multiple of 4 and at least 4
//
// Optional feature macro:
//   ALU_SEQ_ZERO_EN  builds the zero-result flag behind out_zero; without it
//                    out_zero is tied low and the flag register is not built
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       request handshake
//   in_s, in_m, in_cn         74181 function select, mode (1 = logic), carry-in
//   in_a, in_b                operands
//   out_valid / out_ready     result handshake
//   out_f, out_cn, out_zero   result, carry out of the top nibble, result == 0
//   alu_s, alu_m, alu_a,
//   alu_b, alu_cn             drive the external ALU (registered sources only)
//   alu_f, alu_cn_4           combinational result returned by the ALU
// ---------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_s,
  input  logic             in_m,
  input  logic             in_cn,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  output logic             out_cn,
  output logic             out_zero,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn_4
);

  localparam int NIB = WIDTH / 4;
  // A single-nibble build still keeps a 1-bit counter, which simply stays 0.
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_s_q, op_s_d;
  logic             op_m_q, op_m_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             out_valid_q, out_valid_d;
`ifdef ALU_SEQ_ZERO_EN
  logic             zero_q, zero_d;
`endif

  logic             accept;
  logic             load;

  // A new request can land while idle, or in the DONE cycle whose result is
  // being consumed, which lets consecutive operations overlap by one cycle.
  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // ALU drive comes only from registers, so the external ALU path starts at
  // a flop and never sees the requester's inputs combinationally.
  assign alu_s  = op_s_q;
  assign alu_m  = op_m_q;
  assign alu_a  = op_a_q[{cnt_q, 2'b00} +: 4];
  assign alu_b  = op_b_q[{cnt_q, 2'b00} +: 4];
  assign alu_cn = carry_q;

  assign out_valid = out_valid_q;
  assign out_f     = res_q;
  assign out_cn    = carry_q;
`ifdef ALU_SEQ_ZERO_EN
  assign out_zero  = out_valid_q & zero_q;
`else
  assign out_zero  = 1'b0;
`endif

  // Next-state logic: capture a request, step one nibble per RUN cycle
  // (carry is stored exactly as the ALU returns it, in either mode), then
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d  = state_q;
    op_s_d   = op_s_q;
    op_m_d   = op_m_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
`ifdef ALU_SEQ_ZERO_EN
    zero_d   = zero_q;
`endif
    load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        load = accept;
      end
      RUN: begin
        res_d[{cnt_q, 2'b00} +: 4] = alu_f;
        carry_d = alu_cn_4;
`ifdef ALU_SEQ_ZERO_EN
        if (alu_f != 4'h0) begin
          zero_d = 1'b0;
        end
`endif
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          load    = accept;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      state_d = RUN;
      op_s_d  = in_s;
      op_m_d  = in_m;
      op_a_d  = in_a;
      op_b_d  = in_b;
      carry_d = in_cn;
      cnt_d   = '0;
      res_d   = '0;
`ifdef ALU_SEQ_ZERO_EN
      zero_d  = 1'b1;
`endif
    end

    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      op_s_q      <= '0;
      op_m_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef ALU_SEQ_ZERO_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_s_q      <= op_s_d;
      op_m_q      <= op_m_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_SEQ_ZERO_EN
      zero_q      <= zero_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//
// Drives a 16-bit and a 4-bit alu_seq, each wired to a behavioural 4-bit
// 74181 model (active-high data, active-low carry). Directed requests push
// hand-computed results into per-instance queues; monitors pop and compare
// whenever a result handshake happens.
// ---------------------------------------------------------------------------
module tb_alu_seq;

  typedef struct packed {
    logic [15:0] f;
    logic        cn;
    logic        zero;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  // 16-bit instance signals
  logic        in_valid16, in_ready16, in_m16, in_cn16;
  logic [3:0]  in_s16;
  logic [15:0] in_a16, in_b16, out_f16;
  logic        out_valid16, out_ready16, out_cn16, out_zero16;
  logic [3:0]  alu_s16, alu_a16, alu_b16, alu_f16;
  logic        alu_m16, alu_cn16, alu_cn_4_16;

  // 4-bit instance signals
  logic        in_valid4, in_ready4, in_m4, in_cn4;
  logic [3:0]  in_s4, in_a4, in_b4, out_f4;
  logic        out_valid4, out_ready4, out_cn4, out_zero4;
  logic [3:0]  alu_s4, alu_a4, alu_b4, alu_f4;
  logic        alu_m4, alu_cn4, alu_cn_4_4;

  exp_t q16[$];
  exp_t q4[$];
  int   pop16Cyc[$];
  int   pop4Cyc[$];
  int   acceptCyc;

  // Behavioural 74181: returns {cn_4, f}. Carry-in/out are active low.
  function automatic logic [4:0] aluModel(input logic [3:0] s, input logic m,
                                          input logic cn, input logic [3:0] a,
                                          input logic [3:0] b);
    logic [3:0] x, y, f;
    logic [4:0] sum;
    x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {4'b0000, ~cn};
    f   = m ? ~(x ^ y) : sum[3:0];
    return {~sum[4], f};
  endfunction

  function automatic logic zexp(input logic z);
`ifdef ALU_SEQ_ZERO_EN
    return z;
`else
    return 1'b0 & z;
`endif
  endfunction

  assign {alu_cn_4_16, alu_f16} = aluModel(alu_s16, alu_m16, alu_cn16, alu_a16, alu_b16);
  assign {alu_cn_4_4, alu_f4}   = aluModel(alu_s4, alu_m4, alu_cn4, alu_a4, alu_b4);

  alu_seq #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_s(in_s16), .in_m(in_m16), .in_cn(in_cn16),
    .in_a(in_a16), .in_b(in_b16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_f(out_f16), .out_cn(out_cn16), .out_zero(out_zero16),
    .alu_s(alu_s16), .alu_m(alu_m16), .alu_a(alu_a16), .alu_b(alu_b16),
    .alu_cn(alu_cn16), .alu_f(alu_f16), .alu_cn_4(alu_cn_4_16)
  );

  alu_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_s(in_s4), .in_m(in_m4), .in_cn(in_cn4),
    .in_a(in_a4), .in_b(in_b4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_f(out_f4), .out_cn(out_cn4), .out_zero(out_zero4),
    .alu_s(alu_s4), .alu_m(alu_m4), .alu_a(alu_a4), .alu_b(alu_b4),
    .alu_cn(alu_cn4), .alu_f(alu_f4), .alu_cn_4(alu_cn_4_4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Presents one request, waits (bounded) for acceptance, and queues the
  // hand-computed result when push is set.
  task automatic applyStimulus(input bit w4, input logic [3:0] s, input logic m,
                               input logic cn, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] expF,
                               input logic expCn, input logic expZero,
                               input bit push);
    int budget;
    exp_t e;
    e = '{f: expF, cn: expCn, zero: zexp(expZero)};
    @(negedge clk);
    if (w4) begin
      in_valid4 = 1'b1; in_s4 = s; in_m4 = m; in_cn4 = cn;
      in_a4 = a[3:0]; in_b4 = b[3:0];
    end else begin
      in_valid16 = 1'b1; in_s16 = s; in_m16 = m; in_cn16 = cn;
      in_a16 = a; in_b16 = b;
    end
    budget = 50;
    while (!(w4 ? in_ready4 : in_ready16) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL acceptTimeout: in_ready got 0 expected 1");
    end
    if (push) begin
      if (w4) q4.push_back(e);
      else    q16.push_back(e);
    end
    @(posedge clk);
    acceptCyc = cyc;
    #1;
    in_valid4  = 1'b0;
    in_valid16 = 1'b0;
  endtask

  // Result monitors: compare whenever a result handshake is seen.
  always @(negedge clk) begin
    if (!rst && out_valid16 && out_ready16) begin
      pop16Cyc.push_back(cyc);
      if (q16.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected16: got f=0x%0h expected no result", out_f16);
      end else begin
        exp_t e;
        e = q16.pop_front();
        checkOutput("out_f16", 32'(out_f16), 32'(e.f));
        checkOutput("out_cn16", 32'(out_cn16), 32'(e.cn));
        checkOutput("out_zero16", 32'(out_zero16), 32'(e.zero));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid4 && out_ready4) begin
      pop4Cyc.push_back(cyc);
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected4: got f=0x%0h expected no result", out_f4);
      end else begin
        exp_t e;
        e = q4.pop_front();
        checkOutput("out_f4", 32'(out_f4), 32'(e.f[3:0]));
        checkOutput("out_cn4", 32'(out_cn4), 32'(e.cn));
        checkOutput("out_zero4", 32'(out_zero4), 32'(e.zero));
      end
    end
  end

  initial begin
    int budget;
    int seen;
    int n;
    int acc1;
    logic [3:0] aSeq [4];
    cyc = 0; total = 0; bad = 0; acceptCyc = 0;
    rst = 1'b1;
    in_valid16 = 0; in_s16 = 0; in_m16 = 0; in_cn16 = 0; in_a16 = 0; in_b16 = 0;
    in_valid4 = 0; in_s4 = 0; in_m4 = 0; in_cn4 = 0; in_a4 = 0; in_b4 = 0;
    out_ready16 = 1'b1;
    out_ready4  = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready16), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid16), 32'd0);
    checkOutput("rst_out_f", 32'(out_f16), 32'd0);
    checkOutput("rst_out_cn", 32'(out_cn16), 32'd0);
    checkOutput("rst_out_zero", 32'(out_zero16), 32'd0);
    checkOutput("rst_alu_s", 32'(alu_s16), 32'd0);
    checkOutput("rst_alu_m", 32'(alu_m16), 32'd0);
    checkOutput("rst_alu_ab", 32'({alu_a16, alu_b16}), 32'd0);
    checkOutput("rst_alu_cn", 32'(alu_cn16), 32'd0);
    checkOutput("rst_out_valid4", 32'(out_valid4), 32'd0);
    rst = 1'b0;

    // Reset in the middle of RUN discards the operation
    applyStimulus(1'b0, 4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("run_alu_a_n0", 32'(alu_a16), 32'h4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", 32'(in_ready16), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid16), 32'd0);
    checkOutput("midrst_alu_a", 32'(alu_a16), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid16) seen++;
    end
    checkOutput("no_result_after_rst", 32'(seen), 32'd0);

    // FFFF + 0001: all-zero sum with carry out, latency of 4 cycles
    applyStimulus(1'b0, 4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("latency_valid_%0d", i), 32'(out_valid16), 32'(i == 4));
    end

    // 00FF + 0001: carry stops at nibble 2, nibble walk F,F,0,0
    aSeq[0] = 4'hF; aSeq[1] = 4'hF; aSeq[2] = 4'h0; aSeq[3] = 4'h0;
    applyStimulus(1'b0, 4'b1001, 1'b0, 1'b1, 16'h00FF, 16'h0001, 16'h0100, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("alu_a_seq_%0d", i), 32'(alu_a16), 32'(aSeq[i]));
    end
    repeat (3) @(negedge clk);

    // Logic XOR, result held while the consumer stalls
    out_ready16 = 1'b0;
    applyStimulus(1'b0, 4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b1, 1'b0, 1'b1);
    budget = 20;
    while (!out_valid16 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("xor_valid_seen", 32'(out_valid16), 32'd1);
    checkOutput("xor_in_ready_stall", 32'(in_ready16), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_valid_%0d", i), 32'(out_valid16), 32'd1);
      checkOutput($sformatf("hold_f_%0d", i), 32'(out_f16), 32'h0FF0);
    end
    @(posedge clk);
    #1 out_ready16 = 1'b1;
    repeat (3) @(negedge clk);

    // Back-to-back: 1234+1111, then 5000-1000 with carry-in asserted
    n = pop16Cyc.size();
    applyStimulus(1'b0, 4'b1001, 1'b0, 1'b1, 16'h1234, 16'h1111, 16'h2345, 1'b1, 1'b0, 1'b1);
    acc1 = acceptCyc;
    applyStimulus(1'b0, 4'b0110, 1'b0, 1'b0, 16'h5000, 16'h1000, 16'h4000, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b_accept_spacing", 32'(acceptCyc - acc1), 32'd5);
    repeat (8) @(negedge clk);
    if (pop16Cyc.size() >= n + 2) begin
      checkOutput("b2b_result_spacing", 32'(pop16Cyc[n+1] - pop16Cyc[n]), 32'd5);
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL b2b_results: got %0d results expected 2", pop16Cyc.size() - n);
    end

    // WIDTH=4: single-cycle RUN
    applyStimulus(1'b1, 4'b1001, 1'b0, 1'b1, 16'h9, 16'h7, 16'h0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("w4_run_valid", 32'(out_valid4), 32'd0);
    @(negedge clk);
    checkOutput("w4_done_valid", 32'(out_valid4), 32'd1);
    applyStimulus(1'b1, 4'b1001, 1'b0, 1'b1, 16'h3, 16'h4, 16'h7, 1'b1, 1'b0, 1'b1);

    repeat (6) @(negedge clk);
    checkOutput("q16_drained", 32'(q16.size()), 32'd0);
    checkOutput("q4_drained", 32'(q4.size()), 32'd0);
    checkOutput("results16_count", 32'(pop16Cyc.size()), 32'd5);
    checkOutput("results4_count", 32'(pop4Cyc.size()), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
